// File: rtl/box_filter_pkg.sv
// Shared definitions for the time-multiplexed box filter: data width, FSM states
// and the running-sum width needed to hold a full window without overflow.
package box_filter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    CLEAR
  } state_t;

  function automatic int sum_width(input int filter_size);
    return DATA_W + $clog2(filter_size);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the
// requester after the last one that was actually served.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last;
  logic [PW-1:0] grant_idx;
  int            idx;

  // Scan farthest-first so the nearest requester after 'last' overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_idx = last;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= PW'(N - 1);
    end else if (advance && |grant) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/box_filter_sched.sv
// Moving-average filter shared by NUM_CH requesters: a round-robin grant picks one
// sample per cycle, and a per-channel history ring keeps each window's running sum.
module box_filter_sched
  import box_filter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int FILTER_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req_valid,
  output logic [NUM_CH-1:0]         req_ready,
  input  logic [NUM_CH*32-1:0]      req_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [31:0]               out_data
);

  localparam int CHW   = $clog2(NUM_CH);
  localparam int FW    = $clog2(FILTER_SIZE);
  localparam int DEPTH = NUM_CH * FILTER_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = sum_width(FILTER_SIZE);

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     clr_cnt;
  logic              sweep_done;
  logic [DATA_W-1:0] hist [DEPTH];
  logic [SW-1:0]     sum  [NUM_CH];
  logic [FW-1:0]     wp   [NUM_CH];
  logic [NUM_CH-1:0] grant;
  logic              can_accept;
  logic              accept;
  logic [CHW-1:0]    sel;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] oldest;
  logic [AW-1:0]     wr_addr;
  logic [SW-1:0]     new_sum;

  assign can_accept = (state == RUN) && !flush && (!out_valid || out_ready);
  assign req_ready  = can_accept ? grant : '0;
  assign accept     = |req_ready;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel = CHW'(i);
    end
  end

  // FILTER_SIZE is a power of two, so {channel, pointer} is a dense history address.
  assign wr_addr    = {sel, wp[sel]};
  assign sample     = req_data[int'(sel)*DATA_W +: DATA_W];
  assign oldest     = hist[wr_addr];
  assign new_sum    = sum[sel] + SW'(sample) - SW'(oldest);
  assign sweep_done = (clr_cnt == AW'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT, CLEAR: if (sweep_done) state_next = RUN;
      RUN:         if (flush) state_next = CLEAR;
      default:     state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state != RUN && !sweep_done) begin
      clr_cnt <= clr_cnt + AW'(1);
    end else begin
      clr_cnt <= '0;
    end
  end

  // History carries no reset; the INIT/CLEAR sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state != RUN) begin
      hist[clr_cnt] <= '0;
    end else if (accept) begin
      hist[wr_addr] <= sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum[i] <= '0;
        wp[i]  <= '0;
      end
    end else if (state != RUN || flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum[i] <= '0;
        wp[i]  <= '0;
      end
    end else if (accept) begin
      sum[sel] <= new_sum;
      wp[sel]  <= wp[sel] + FW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ch    <= sel;
      out_data  <= DATA_W'(new_sum >> FW);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
